// File: rtl/muldiv_wb_buffer.sv
// Muldiv writeback buffer: tracks issued muldiv destinations through a tag pipe and
// arbitrates muldiv results for the shared register-file write port behind the ALU.
module muldiv_wb_buffer #(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 2,
  parameter int DEPTH     = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            md_valid_i,
  input  logic [XLEN-1:0] md_result_i,
  input  logic            alu_wb_en_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            wb_en_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            stall_o,
  output logic            hazard_o,
  output logic            error_o
);

  localparam int LAT = NUM_STAGE - 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SW  = $clog2(DEPTH + LAT + 1);

  // Handshake: a result is consumed only in the cycle its tag reaches the pipe end;
  // md_valid_i and the end-of-pipe tag must coincide, anything else is a protocol error.

  logic [LAT-1:0]  tag_v;
  logic [4:0]      tag_rd [LAT];

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0] ent_v;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            error_q;

  logic            tag_end_v;
  logic [4:0]      arr_rd;
  logic            arr_ok;
  logic            fifo_ne, fifo_full;
  logic            deq, byp, enq_req, enq, ovf;
  logic [SW-1:0]   pipe_cnt, pend_cnt;
  logic            err_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic rs_hit(input logic [4:0] rd);
    return (rd != 5'd0) && ((rd == rs1_i) || (rd == rs2_i));
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue_i;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    tag_rd[0] <= issue_rd_i;
    for (int i = 1; i < LAT; i++) tag_rd[i] <= tag_rd[i-1];
  end

  assign tag_end_v = tag_v[LAT-1];
  assign arr_rd    = tag_rd[LAT-1];
  assign arr_ok    = md_valid_i && tag_end_v && (arr_rd != 5'd0);
  assign fifo_ne   = (count != '0);
  assign fifo_full = (count == CW'(DEPTH));

  // Write-port arbitration: ALU first, then the oldest buffered result, then bypass.
  always_comb begin
    wb_en_o   = 1'b0;
    wb_rd_o   = '0;
    wb_data_o = '0;
    deq       = 1'b0;
    byp       = 1'b0;
    if (!alu_wb_en_i) begin
      if (fifo_ne) begin
        wb_en_o   = 1'b1;
        wb_rd_o   = fifo_rd[rd_ptr];
        wb_data_o = fifo_data[rd_ptr];
        deq       = 1'b1;
      end else if (arr_ok) begin
        wb_en_o   = 1'b1;
        wb_rd_o   = arr_rd;
        wb_data_o = md_result_i;
        byp       = 1'b1;
      end
    end
  end

  assign enq_req = arr_ok && !byp;
  assign enq     = enq_req && (!fifo_full || deq);
  assign ovf     = enq_req && fifo_full && !deq;

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LAT; i++) pipe_cnt = pipe_cnt + SW'(tag_v[i]);
  end

  assign pend_cnt = SW'(count) + pipe_cnt;
  assign stall_o  = (pend_cnt >= SW'(DEPTH));

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < LAT; i++)
      if (tag_v[i] && rs_hit(tag_rd[i])) hazard_o = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (ent_v[i] && rs_hit(fifo_rd[i])) hazard_o = 1'b1;
    if (enq_req && rs_hit(arr_rd)) hazard_o = 1'b1;
  end

  assign err_set = (issue_i && stall_o) || (md_valid_i && !tag_end_v) ||
                   (tag_end_v && !md_valid_i) || ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_v   <= '0;
      error_q <= 1'b0;
    end else begin
      if (deq) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        ent_v[rd_ptr] <= 1'b0;
      end
      // When full with a simultaneous dequeue, wr_ptr == rd_ptr and the set below wins.
      if (enq) begin
        wr_ptr        <= ptr_inc(wr_ptr);
        ent_v[wr_ptr] <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (err_set) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= arr_rd;
      fifo_data[wr_ptr] <= md_result_i;
    end
  end

  assign error_o = error_q;

endmodule

// File: tb/tb_muldiv_wb_buffer.sv
// Bench for muldiv_wb_buffer: directed cycle table, hand sequences for overflow/reset,
// then constrained-random traffic checked against a queue-based reference model.
module tb_muldiv_wb_buffer;

  localparam int XLEN      = 32;
  localparam int NUM_STAGE = 2;
  localparam int DEPTH     = 2;
  localparam int LAT       = NUM_STAGE - 1;
  localparam int ENT_W     = 5 + XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_i = 1'b0;
  logic [4:0]      issue_rd_i = '0;
  logic            md_valid_i = 1'b0;
  logic [XLEN-1:0] md_result_i = '0;
  logic            alu_wb_en_i = 1'b0;
  logic [4:0]      rs1_i = '0;
  logic [4:0]      rs2_i = '0;
  logic            wb_en_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            stall_o;
  logic            hazard_o;
  logic            error_o;

  muldiv_wb_buffer #(.XLEN(XLEN), .NUM_STAGE(NUM_STAGE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i), .alu_wb_en_i(alu_wb_en_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .stall_o(stall_o), .hazard_o(hazard_o), .error_o(error_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic iss; logic [4:0] rd; logic mdv; logic [31:0] d; logic alu; logic [4:0] r1; logic [4:0] r2;
    logic e_wb; logic [4:0] e_rd; logic [31:0] e_d; logic e_st; logic e_hz; logic e_er;
  } vec_t;
  vec_t vecs[13];

  // reference model state
  typedef struct { logic [4:0] rd; int due; } tag_t;
  tag_t pipe_q[$];
  logic [ENT_W-1:0] exp_q[$];
  logic err_m;
  int   cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_wb, input logic [4:0] e_rd,
                            input logic [31:0] e_d, input logic e_st, input logic e_hz,
                            input logic e_er);
    chk({tag, ".wb_en"},   64'(wb_en_o),   64'(e_wb));
    chk({tag, ".wb_rd"},   64'(wb_rd_o),   64'(e_rd));
    chk({tag, ".wb_data"}, 64'(wb_data_o), 64'(e_d));
    chk({tag, ".stall"},   64'(stall_o),   64'(e_st));
    chk({tag, ".hazard"},  64'(hazard_o),  64'(e_hz));
    chk({tag, ".error"},   64'(error_o),   64'(e_er));
  endtask

  // driver: inputs change mid-cycle, outputs are sampled 1ns later
  task automatic step(input logic iss, input logic [4:0] rd, input logic mdv,
                      input logic [31:0] d, input logic alu, input logic [4:0] r1,
                      input logic [4:0] r2);
    @(negedge clk);
    issue_i = iss; issue_rd_i = rd; md_valid_i = mdv; md_result_i = d;
    alu_wb_en_i = alu; rs1_i = r1; rs2_i = r2;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    issue_i = 0; issue_rd_i = 0; md_valid_i = 0; md_result_i = 0;
    alu_wb_en_i = 0; rs1_i = 0; rs2_i = 0;
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic iss, input logic [4:0] rd, input logic mdv,
                              input logic [31:0] d, input logic alu, input logic [4:0] r1,
                              input logic [4:0] r2, input logic e_wb, input logic [4:0] e_rd,
                              input logic [31:0] e_d, input logic e_st, input logic e_hz,
                              input logic e_er);
    vec_t v;
    v.iss = iss; v.rd = rd; v.mdv = mdv; v.d = d; v.alu = alu; v.r1 = r1; v.r2 = r2;
    v.e_wb = e_wb; v.e_rd = e_rd; v.e_d = e_d; v.e_st = e_st; v.e_hz = e_hz; v.e_er = e_er;
    return v;
  endfunction

  // One random cycle: picks legal stimulus from the model, checks, then advances the model.
  task automatic rand_cycle(input logic allow_issue, input logic spurious);
    logic st, arr, iss, mdv, alu, e_wb, hz, written;
    logic [4:0] rd, r1, r2, arr_rd, e_rd;
    logic [31:0] d, e_d;
    logic [ENT_W-1:0] head;
    st     = (exp_q.size() + pipe_q.size()) >= DEPTH;
    arr    = (pipe_q.size() != 0) && (pipe_q[0].due == cyc);
    arr_rd = arr ? pipe_q[0].rd : 5'd0;
    iss    = allow_issue && !st && ($urandom_range(0, 1) == 1);
    rd     = 5'($urandom_range(0, 7));
    mdv    = arr || spurious;
    d      = $urandom;
    alu    = ($urandom_range(0, 2) == 0);
    r1     = 5'($urandom_range(0, 7));
    r2     = 5'($urandom_range(0, 7));
    step(iss, rd, mdv, d, alu, r1, r2);
    hz = 1'b0;
    foreach (pipe_q[i])
      if (pipe_q[i].rd != 0 && (pipe_q[i].rd == r1 || pipe_q[i].rd == r2)) hz = 1'b1;
    foreach (exp_q[i])
      if (exp_q[i][ENT_W-1:XLEN] != 0 &&
          (exp_q[i][ENT_W-1:XLEN] == r1 || exp_q[i][ENT_W-1:XLEN] == r2)) hz = 1'b1;
    e_wb = 0; e_rd = 0; e_d = 0; written = 0;
    if (!alu) begin
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        e_wb = 1; e_rd = head[ENT_W-1:XLEN]; e_d = head[XLEN-1:0];
      end else if (arr && mdv && arr_rd != 0) begin
        e_wb = 1; e_rd = arr_rd; e_d = d; written = 1;
      end
    end
    check_outs("rand", e_wb, e_rd, e_d, st, hz, err_m);
    if (iss && st) err_m = 1;
    if (mdv && !arr) err_m = 1;
    if (arr && !mdv) err_m = 1;
    if (arr && mdv && arr_rd != 0 && !written) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({arr_rd, d});
      else err_m = 1;
    end
    if (arr) void'(pipe_q.pop_front());
    if (iss) pipe_q.push_back('{rd, cyc + LAT});
    cyc++;
  endtask

  initial begin
    vecs[0]  = mk(1, 5, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,  0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 32'h42,       0, 0, 0,  1, 5, 32'h42, 0, 0, 0);
    vecs[2]  = mk(1, 3, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,  0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 32'h11,       1, 3, 0,  0, 0, 32'h0,  0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 3, 0,  0, 0, 32'h0,  0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 3, 0,  1, 3, 32'h11, 0, 1, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,  0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 0,  0, 0, 32'h0,  0, 0, 0);
    vecs[8]  = mk(1, 4, 0, 32'h0,        1, 0, 0,  0, 0, 32'h0,  0, 0, 0);
    vecs[9]  = mk(1, 6, 1, 32'hA,        1, 4, 6,  0, 0, 32'h0,  0, 1, 0);
    vecs[10] = mk(0, 0, 1, 32'hB,        0, 0, 6,  1, 4, 32'hA,  1, 1, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 4, 0,  1, 6, 32'hB,  0, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 6, 0,  0, 0, 32'h0,  0, 0, 0);

    apply_reset();
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].iss, vecs[i].rd, vecs[i].mdv, vecs[i].d, vecs[i].alu, vecs[i].r1, vecs[i].r2);
      check_outs($sformatf("vec%0d", i), vecs[i].e_wb, vecs[i].e_rd, vecs[i].e_d,
                 vecs[i].e_st, vecs[i].e_hz, vecs[i].e_er);
    end

    // Back-to-back issues with ALU owning the port, illegal issue, overflow drop, drain.
    apply_reset();
    step(1, 1, 0, 0, 1, 0, 0);    check_outs("ovf0", 0, 0, 0, 0, 0, 0);
    step(1, 2, 1, 32'h1, 1, 0, 0); check_outs("ovf1", 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h2, 1, 0, 0); check_outs("ovf2", 0, 0, 0, 1, 0, 0);
    step(1, 7, 0, 0, 1, 2, 0);    check_outs("ovf3", 0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 32'h99, 1, 7, 0); check_outs("ovf4", 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 7, 0);    check_outs("ovf5", 1, 1, 32'h1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);    check_outs("ovf6", 1, 2, 32'h2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);    check_outs("ovf7", 0, 0, 0, 0, 0, 1);

    // Reset while a result is buffered and a tag is in flight.
    apply_reset();
    step(1, 9, 0, 0, 1, 0, 0);        check_outs("rst0", 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h55, 1, 0, 0);   check_outs("rst1", 0, 0, 0, 0, 0, 0);
    step(1, 10, 0, 0, 1, 0, 0);       check_outs("rst2", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 9, 10);       check_outs("rst3", 1, 9, 32'h55, 1, 1, 0);
    #1 rst_n = 1'b0;
    #1 check_outs("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 9, 10);
      check_outs($sformatf("rst_after%0d", i), 0, 0, 0, 0, 0, 0);
    end

    // Randomized traffic against the reference model.
    apply_reset();
    pipe_q.delete();
    exp_q.delete();
    err_m = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 300; i++) rand_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
